// File: rtl/pdm_playback_unit.sv
// PCM-to-PDM playback path: one-entry sample buffer feeding a first-order
// sigma-delta modulator with zero-order-hold interpolation and a programmable PDM clock.
module pdm_playback_unit #(
    parameter int DATA_WIDTH    = 16,
    parameter int DIVISOR_WIDTH = 7,
    parameter int FACTOR_WIDTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [DIVISOR_WIDTH-1:0] clock_divisor_i,
    input  logic [FACTOR_WIDTH-1:0]  oversampling_factor_i,
    input  logic [DATA_WIDTH-1:0]    sample_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    output logic                     pdm_clk_o,
    output logic                     pdm_data_o,
    output logic                     underrun_o,
    output logic                     idle_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [DIVISOR_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [FACTOR_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    cur_q, cur_d;
    logic [DATA_WIDTH-1:0]    buf_q, buf_d;
    logic                     full_q, full_d;
    logic                     pdm_clk_q, pdm_clk_d;
    logic                     pdm_data_q, pdm_data_d;
    logic                     underrun_q, underrun_d;

    logic                     xfer_s;
    logic                     step_s;
    logic                     load_s;
    logic [DATA_WIDTH-1:0]    operand_s;
    logic [DATA_WIDTH-1:0]    offset_s;
    logic [DATA_WIDTH:0]      sum_s;

    // Next-state logic: divider, step scheduling, modulator update and input buffer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        cur_d      = cur_q;
        pdm_clk_d  = pdm_clk_q;
        pdm_data_d = pdm_data_q;
        underrun_d = 1'b0;
        step_s     = 1'b0;
        load_s     = 1'b0;
        xfer_s     = sample_valid_i && !full_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d  = {DIVISOR_WIDTH{1'b0}};
                bit_cnt_d  = {FACTOR_WIDTH{1'b0}};
                acc_d      = {DATA_WIDTH{1'b0}};
                cur_d      = {DATA_WIDTH{1'b0}};
                pdm_clk_d  = 1'b0;
                pdm_data_d = 1'b0;
                if (enable_i) begin
                    state_d = ST_RUN;
                    step_s  = 1'b1;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d    = ST_IDLE;
                    div_cnt_d  = {DIVISOR_WIDTH{1'b0}};
                    bit_cnt_d  = {FACTOR_WIDTH{1'b0}};
                    acc_d      = {DATA_WIDTH{1'b0}};
                    cur_d      = {DATA_WIDTH{1'b0}};
                    pdm_clk_d  = 1'b0;
                    pdm_data_d = 1'b0;
                end else if (div_cnt_q >= clock_divisor_i) begin
                    // Falling PDM clock edge is the modulator step.
                    div_cnt_d = {DIVISOR_WIDTH{1'b0}};
                    pdm_clk_d = !pdm_clk_q;
                    step_s    = pdm_clk_q;
                    load_s    = pdm_clk_q && (bit_cnt_q >= oversampling_factor_i);
                end else begin
                    div_cnt_d = div_cnt_q + DIVISOR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            operand_s = full_q ? buf_q : {DATA_WIDTH{1'b0}};
        end else begin
            operand_s = cur_q;
        end
        offset_s = {~operand_s[DATA_WIDTH-1], operand_s[DATA_WIDTH-2:0]};
        sum_s    = {1'b0, acc_q} + {1'b0, offset_s};

        if (step_s) begin
            pdm_data_d = sum_s[DATA_WIDTH];
            acc_d      = sum_s[DATA_WIDTH-1:0];
            if (load_s) begin
                cur_d      = operand_s;
                bit_cnt_d  = {FACTOR_WIDTH{1'b0}};
                underrun_d = !full_q;
            end else begin
                bit_cnt_d  = bit_cnt_q + FACTOR_WIDTH'(1);
            end
        end else begin
            underrun_d = 1'b0;
        end

        // An empty-buffer load may coincide with a transfer; the new sample waits for the next load.
        full_d = (full_q && !load_s) || xfer_s;
        if (xfer_s) begin
            buf_d = sample_i;
        end else begin
            buf_d = buf_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= {DIVISOR_WIDTH{1'b0}};
            bit_cnt_q  <= {FACTOR_WIDTH{1'b0}};
            acc_q      <= {DATA_WIDTH{1'b0}};
            cur_q      <= {DATA_WIDTH{1'b0}};
            buf_q      <= {DATA_WIDTH{1'b0}};
            full_q     <= 1'b0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready_o = !full_q;
    assign pdm_clk_o      = pdm_clk_q;
    assign pdm_data_o     = pdm_data_q;
    assign underrun_o     = underrun_q;
    assign idle_o         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pdm_playback_unit.sv
// Scoreboard bench for pdm_playback_unit: expected PDM bits are queued per scenario
// and popped at each rising pdm_clk_o; cycle-exact checks cover clock and underrun timing.
module tb_pdm_playback_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [6:0]  clock_divisor_i = 7'd0;
    logic [7:0]  oversampling_factor_i = 8'd0;
    logic [15:0] sample_i = 16'd0;
    logic        sample_valid_i = 1'b0;
    logic        sample_ready_o;
    logic        pdm_clk_o;
    logic        pdm_data_o;
    logic        underrun_o;
    logic        idle_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned bad_change = 0;
    bit          exp_q[$];
    logic        mon_en = 1'b0;
    logic        prev_clk = 1'b0;
    logic        prev_data = 1'b0;
    logic        prev_idle = 1'b1;

    pdm_playback_unit dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .enable_i              (enable_i),
        .clock_divisor_i       (clock_divisor_i),
        .oversampling_factor_i (oversampling_factor_i),
        .sample_i              (sample_i),
        .sample_valid_i        (sample_valid_i),
        .sample_ready_o        (sample_ready_o),
        .pdm_clk_o             (pdm_clk_o),
        .pdm_data_o            (pdm_data_o),
        .underrun_o            (underrun_o),
        .idle_o                (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: pop one expected bit per rising pdm_clk_o; track data changes off the falling edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (!prev_clk && pdm_clk_o && exp_q.size() > 0) begin
                check_eq("pdm_bit", 32'(pdm_data_o), 32'(exp_q.pop_front()));
            end
            if ((pdm_data_o != prev_data) && !(prev_clk && !pdm_clk_o) && !prev_idle && !idle_o) begin
                bad_change++;
            end
        end
        prev_clk  <= pdm_clk_o;
        prev_data <= pdm_data_o;
        prev_idle <= idle_o;
    end

    task automatic do_reset();
        rst_i = 1'b1;
        enable_i = 1'b0;
        sample_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic preload(input logic [15:0] s);
        sample_i = s;
        sample_valid_i = 1'b1;
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        check_eq("preload_ready", 32'(sample_ready_o), 32'd0);
    endtask

    task automatic start_run();
        enable_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic stop_run(input string tag, input int cycles);
        repeat (cycles) @(negedge clk_i);
        check_eq(tag, exp_q.size(), 32'd0);
        exp_q.delete();
        enable_i = 1'b0;
        @(negedge clk_i);
        check_eq("stop_idle", 32'(idle_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and static idle.
        do_reset();
        mon_en = 1'b1;
        check_eq("rst_clk", 32'(pdm_clk_o), 32'd0);
        check_eq("rst_data", 32'(pdm_data_o), 32'd0);
        check_eq("rst_ready", 32'(sample_ready_o), 32'd1);
        check_eq("rst_underrun", 32'(underrun_o), 32'd0);
        check_eq("rst_idle", 32'(idle_o), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check_eq("idle_static", {29'd0, idle_o, pdm_clk_o, pdm_data_o}, 32'h4);
        end

        // Midscale: d=0, f=3.
        clock_divisor_i = 7'd0;
        oversampling_factor_i = 8'd3;
        preload(16'h0000);
        for (int i = 0; i < 16; i++) exp_q.push_back(i[0]);
        start_run();
        check_eq("mid_idle", 32'(idle_o), 32'd0);
        check_eq("mid_clk0", 32'(pdm_clk_o), 32'd0);
        check_eq("mid_ready", 32'(sample_ready_o), 32'd1);
        check_eq("mid_no_underrun", 32'(underrun_o), 32'd0);
        stop_run("mid_bits_left", 34);

        // Extremes: most negative and most positive samples.
        do_reset();
        clock_divisor_i = 7'd1;
        oversampling_factor_i = 8'd255;
        preload(16'h8000);
        for (int i = 0; i < 12; i++) exp_q.push_back(1'b0);
        start_run();
        stop_run("neg_bits_left", 50);

        do_reset();
        clock_divisor_i = 7'd0;
        preload(16'h7FFF);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 19; i++) exp_q.push_back(1'b1);
        start_run();
        stop_run("pos_bits_left", 42);

        // Density 3/4 with d=2, f=7, plus PDM clock waveform.
        do_reset();
        clock_divisor_i = 7'd2;
        oversampling_factor_i = 8'd7;
        preload(16'h4000);
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 4 != 0);
        start_run();
        for (int c = 0; c < 48; c++) begin
            check_eq("dens_clk", 32'(pdm_clk_o), 32'((c / 3) % 2));
            @(negedge clk_i);
        end
        stop_run("dens_bits_left", 0);

        // Underrun cadence, and a transfer landing on a load-step edge.
        do_reset();
        clock_divisor_i = 7'd1;
        oversampling_factor_i = 8'd1;
        for (int i = 0; i < 8; i++) exp_q.push_back(i[0]);
        exp_q.push_back(1'b1);
        start_run();
        for (int c = 0; c < 40; c++) begin
            check_eq("ur_pulse", 32'(underrun_o), 32'((c % 8 == 0) && (c != 24)));
            if (c == 15) begin
                sample_i = 16'h4000;
                sample_valid_i = 1'b1;
            end
            if (c == 16) begin
                check_eq("ur_xfer_ready", 32'(sample_ready_o), 32'd0);
                sample_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        stop_run("ur_bits_left", 0);

        // Disable with a full buffer, re-enable, then reset mid-run.
        do_reset();
        clock_divisor_i = 7'd0;
        oversampling_factor_i = 8'd3;
        start_run();
        check_eq("dis_first_underrun", 32'(underrun_o), 32'd1);
        repeat (3) @(negedge clk_i);
        preload(16'h4000);
        enable_i = 1'b0;
        @(negedge clk_i);
        check_eq("dis_state", {28'd0, idle_o, sample_ready_o, pdm_clk_o, pdm_data_o}, 32'h8);
        repeat (3) @(negedge clk_i);
        check_eq("dis_kept", 32'(sample_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(i != 0);
        start_run();
        check_eq("reen_underrun", 32'(underrun_o), 32'd0);
        check_eq("reen_ready", 32'(sample_ready_o), 32'd1);
        repeat (10) @(negedge clk_i);
        check_eq("reen_bits_left", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("midrst_state",
                 {27'd0, idle_o, sample_ready_o, underrun_o, pdm_clk_o, pdm_data_o}, 32'h18);
        enable_i = 1'b0;
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check_eq("post_rst_idle", {29'd0, idle_o, pdm_clk_o, pdm_data_o}, 32'h4);

        check_eq("data_align", bad_change, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pdm_playback_unit.md
# pdm_playback_unit

Audio output path of the APU: accepts signed PCM samples from the waveform generator/mixer over a valid/ready handshake and drives a 1-bit PDM stream plus PDM clock to an external class-D amplifier or filter. It is the transmit-side counterpart of the audio capture unit. It uses the same 7-bit clock divisor and 8-bit decimation-factor semantics, and runs a first-order sigma-delta modulator with zero-order-hold interpolation.

## Interface
- DATA_WIDTH, 16, PCM sample width (signed two's complement)
- DIVISOR_WIDTH, 7, width of clock divisor
- FACTOR_WIDTH, 8, width of oversampling factor
- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  reset; synchronous and active-high
- enable_i  in  1  run modulator; low forces IDLE
- clock_divisor_i  in  DIVISOR_WIDTH  PDM half-period = clock_divisor_i+1 clk_i cycles
- oversampling_factor_i  in  FACTOR_WIDTH  PDM bits per sample = factor+1
- sample_i  in  DATA_WIDTH  PCM sample
- sample_valid_i  in  1  sample_i valid
- sample_ready_o  out  1  one-entry input buffer empty
- pdm_clk_o  out  1  PDM clock to amplifier
- pdm_data_o  out  1  PDM bitstream; stable around pdm_clk_o rising edge
- underrun_o  out  1  one-cycle pulse: sample needed, buffer empty
- idle_o  out  1  FSM in IDLE

## Operation
- Reset: pdm_clk_o=0, pdm_data_o=0, sample_ready_o=1, underrun_o=0, idle_o=1. Accumulator, divider counter, bit counter, current sample, and buffer-full flag all cleared.
- Input buffer: one register plus full flag. sample_ready_o = !full, independent of enable_i. A transfer on valid&&ready sets full at the next edge.
- FSM IDLE: pdm_clk_o=0, pdm_data_o=0, accumulator=0, counters=0.
  - enable_i high in IDLE: go to RUN and perform a load step at that edge.
- FSM RUN: divider counter increments each cycle.
  - When counter ≥ clock_divisor_i: counter←0 and pdm_clk_o toggles.
  - A toggle 1→0 is a modulator step.
  - enable_i low in RUN: next edge returns to IDLE. Accumulator, current sample and counters are cleared. The input buffer content is retained.
- Step operand: u = operand with MSB inverted (offset binary). sum = {1'b0,acc} + u (DATA_WIDTH+1 bits). pdm_data_o←sum[MSB], acc←sum[DATA_WIDTH-1:0].
- Load step: the first step after enable, or any step with bit_cnt ≥ oversampling_factor_i.
  - Buffer full: operand = buffer; current←buffer; full cleared; bit_cnt←0.
  - Buffer empty: operand = 0 (silence); current←0; bit_cnt←0; underrun_o pulses for one cycle.
- Other steps: operand = current; bit_cnt++.
- Simultaneous transfer and load step with empty buffer: underrun is reported, silence is used, and the incoming sample is written to the buffer.
- clock_divisor_i and oversampling_factor_i are read live; the ≥ compare makes a decrease take effect immediately without wrap.

## Timing
- Enable edge E: pdm_data_o gets its first bit at E, with pdm_clk_o=0 and idle_o=0.
- pdm_clk_o rises at E+(d+1) and falls (next step) at E+2(d+1), where d = clock_divisor_i.
- pdm_clk_o period = 2(d+1) cycles, 50% duty. pdm_data_o changes only on falling edges of pdm_clk_o.
- Sample period = (f+1)·2(d+1) cycles, where f = oversampling_factor_i. sample_ready_o rises the cycle after each load step that empties the buffer.
- underrun_o is asserted in the cycle after the load step edge.
- Reset mid-RUN: all outputs return to reset values at that edge.

## Test plan
- Reset/idle: assert rst_i during RUN -> pdm_clk_o=0, pdm_data_o=0, sample_ready_o=1, idle_o=1 next cycle; enable held low -> outputs static.
- Midscale: d=0, f=3, sample 0x0000 preloaded, enable -> pdm_clk_o period 2 cycles; pdm_data_o=0,1,0,1,...; sample_ready_o high 1 cycle after enable, then one load every 8 cycles.
- Extremes: sample 0x8000 -> all-zero stream. Sample 0x7FFF -> 0,1,1,1,... (one zero per 65536 bits).
- Density: sample 0x4000, d=2, f=7 -> repeating 0,1,1,1 (3/4 ones); data changes every 6 cycles, aligned to pdm_clk_o falls.
- Underrun: never assert valid, enable -> underrun_o pulse at first load and every 2(d+1)(f+1) cycles; stream = midscale 0,1 pattern. Present valid on the load-step cycle -> underrun still pulses; the sample is used at the next load.
- Disable mid-stream: drop enable_i while buffer is full -> IDLE next cycle, buffer kept, sample_ready_o=0. Re-enable -> buffered sample consumed at first step with no underrun.
